soc_system_adc_pio: RTL and testbench
=====================================

SOC_SYSTEM_ADC_PIO -- requirements
Module: soc_system_adc_pio

Interface
REQ-001 Parameter DATA_W, default 20, sample and port width.
REQ-002 Parameter FIFO_DEPTH, default 8, sample FIFO depth; power of two only.
REQ-003 clk  input  1  system clock.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 address  input  3  Avalon-MM word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 read_n  input  1  read strobe, active-low.
REQ-008 write_n  input  1  write strobe, active-low.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  read data, combinational, read latency 0.
REQ-011 in_port  input  DATA_W  ADC sample bus, asynchronous to clk.
REQ-012 in_strobe  input  1  sample-ready strobe, asynchronous; a rising edge marks a new sample.
REQ-013 irq  output  1  level interrupt, active-high.

Function
REQ-014 in_port SHALL pass through a 2-flop synchronizer (in_sync); in_strobe SHALL pass through a 3-flop chain, and push_ev = stage2 & ~stage3.
REQ-015 Register map: 0 DATA (RO: in_sync); 1 FIFO (RO, pops); 2 IRQ_MASK (RW, bits[1:0]); 3 STATUS; 4 CONTROL (RW); 5-7 SHALL read 0 and ignore writes.
REQ-016 Read of FIFO: readdata[DATA_W-1:0] = head, bit31 = not-empty, all other bits 0; if not empty, the FIFO SHALL pop on the clk edge ending that read cycle.
REQ-017 Read of FIFO while empty SHALL return 0 and SHALL NOT change state.
REQ-018 STATUS: bits[4:0] count (0..FIFO_DEPTH), bit8 overflow (sticky), bit9 empty, bit10 full.
REQ-019 Write to STATUS with writedata[8]=1 SHALL clear overflow; other bits are ignored.
REQ-020 CONTROL: bit0 enable (RW); bit1 flush (write-1, self-clearing, reads 0).
REQ-021 A push_ev while enable=1 and not full SHALL write in_sync into the FIFO on that edge; count is visible on the 3rd clk edge after in_strobe rises.
REQ-022 push_ev while full and no pop in the same cycle SHALL drop the sample and set overflow.
REQ-023 Simultaneous push and pop while full SHALL accept the push; count stays FIFO_DEPTH; overflow is not set.
REQ-024 Simultaneous push and pop while not full SHALL leave count unchanged.
REQ-025 Flush SHALL empty the FIFO in one cycle and SHALL override any same-cycle push or pop; overflow is unaffected.
REQ-026 push_ev while enable=0 SHALL be ignored.
REQ-027 irq = (IRQ_MASK[0] & not-empty) | (IRQ_MASK[1] & overflow), registered-free combinational OR of registered terms.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be DATA-independent and never exceed FIFO_DEPTH.

Reset
REQ-029 On reset_n low, all synchronizer flops, pointers, count, overflow, IRQ_MASK and CONTROL SHALL clear to 0 asynchronously; irq = 0; readdata of STATUS = 0x200.
REQ-030 Reset asserted mid-operation SHALL discard FIFO contents; no push_ev SHALL be generated by a strobe already high at reset release.

Structure
REQ-031 Package soc_system_adc_pio_pkg SHALL hold register address constants, STATUS/CONTROL bit positions, and DATA_W/FIFO_DEPTH defaults.
REQ-032 One sub-module soc_system_adc_pio_fifo (synchronous FIFO, push/pop/flush, count, full, empty) SHALL hold storage; the top level holds synchronizers, register decode and irq.

Verification
REQ-033 enable=1, in_port=0x12345, pulse in_strobe -> STATUS count=1 by 3rd edge; FIFO read returns 0x80012345; next STATUS = 0x200.
REQ-034 Push 9 samples 0..8 with no reads -> count=8, overflow=1, full=1; 8 reads return 0..7 in order; 9th read returns 0.
REQ-035 FIFO full, in_strobe edge aligned with FIFO read -> read returns oldest, new sample accepted, count=8, overflow=0.
REQ-036 IRQ_MASK=1, push one sample -> irq=1; pop -> irq=0; IRQ_MASK=2 after overflow -> irq=1 until STATUS write 0x100.
REQ-037 4 samples queued, write CONTROL=0x3 coincident with push_ev -> count=0 next cycle, CONTROL reads 0x1.
REQ-038 in_strobe held high, pulse reset_n low then release -> no push, count=0; enable=0 with strobes -> count stays 0.

Source files
------------

// File: rtl/soc_system_adc_pio_pkg.sv
// Shared constants for the ADC sample PIO: register map, bit positions and
// default sizing.
package soc_system_adc_pio_pkg;

    localparam int DATA_W_DEF     = 20;
    localparam int FIFO_DEPTH_DEF = 8;

    // Avalon-MM word addresses
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_FIFO     = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_CONTROL  = 3'd4;

    // STATUS / FIFO read layout
    localparam int STATUS_OVF_BIT   = 8;
    localparam int STATUS_EMPTY_BIT = 9;
    localparam int STATUS_FULL_BIT  = 10;
    localparam int FIFO_VALID_BIT   = 31;

    // CONTROL layout
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_FLUSH_BIT  = 1;

endpackage

// File: rtl/soc_system_adc_pio_fifo.sv
// Synchronous sample FIFO. Flush wins over push/pop; a push while full is
// accepted only when a pop frees a slot on the same edge. Depth must be a
// power of two (>= 2) so the pointers wrap by natural overflow.
module soc_system_adc_pio_fifo #(
    parameter int DATA_W     = 20,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointers and occupancy; flush returns everything to empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage; contents are meaningless once the pointers reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/soc_system_adc_pio.sv
// ADC sample PIO: synchronises an asynchronous sample bus and strobe, queues
// samples in a FIFO and exposes them over a zero-latency Avalon-MM slave.
module soc_system_adc_pio
    import soc_system_adc_pio_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_port,
    input  logic              in_strobe,
    output logic              irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] in_meta_q, in_sync_q;
    logic [2:0]        stb_q;        // [0]=stage1, [1]=stage2, [2]=stage3
    logic [1:0]        settle_q;     // fills with ones once the chain holds real samples
    logic              arm_q, arm_d; // set once the strobe has been seen low after reset
    logic [1:0]        irq_mask_q, irq_mask_d;
    logic              enable_q, enable_d;
    logic              overflow_q, overflow_d;

    logic              rd_en, wr_en;
    logic              push_ev, fifo_push, fifo_pop, fifo_flush;
    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty;
    logic              unused_wdata;

    assign unused_wdata = ^{writedata[31:9], writedata[7:2]};

    assign rd_en      = chipselect & ~read_n;
    assign wr_en      = chipselect & ~write_n;
    assign push_ev    = stb_q[1] & ~stb_q[2] & arm_q;
    assign fifo_push  = push_ev & enable_q;
    assign fifo_pop   = rd_en & (address == ADDR_FIFO);
    assign fifo_flush = wr_en & (address == ADDR_CONTROL) & writedata[CTRL_FLUSH_BIT];

    // Synchronisers for the sample bus and the strobe edge detector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_meta_q <= '0;
            in_sync_q <= '0;
            stb_q     <= '0;
            settle_q  <= '0;
        end else begin
            in_meta_q <= in_port;
            in_sync_q <= in_meta_q;
            stb_q     <= {stb_q[1:0], in_strobe};
            settle_q  <= {settle_q[0], 1'b1};
        end
    end

    // Next state of the software-visible registers and the strobe arm flag.
    always_comb begin
        irq_mask_d = irq_mask_q;
        enable_d   = enable_q;
        overflow_d = overflow_q;
        arm_d      = arm_q | (settle_q[1] & ~stb_q[1]);
        if (wr_en && address == ADDR_IRQ_MASK) irq_mask_d = writedata[1:0];
        if (wr_en && address == ADDR_CONTROL)  enable_d   = writedata[CTRL_ENABLE_BIT];
        if (wr_en && address == ADDR_STATUS && writedata[STATUS_OVF_BIT]) overflow_d = 1'b0;
        // A dropped sample is reported even if software clears on the same edge.
        if (fifo_push && fifo_full && !fifo_pop && !fifo_flush) overflow_d = 1'b1;
    end

    // Register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= '0;
            enable_q   <= 1'b0;
            overflow_q <= 1'b0;
            arm_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            enable_q   <= enable_d;
            overflow_q <= overflow_d;
            arm_q      <= arm_d;
        end
    end

    soc_system_adc_pio_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .data_i  (in_sync_q),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Zero-latency read mux.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[DATA_W-1:0] = in_sync_q;
            ADDR_FIFO: begin
                if (!fifo_empty) begin
                    readdata[DATA_W-1:0]     = fifo_head;
                    readdata[FIFO_VALID_BIT] = 1'b1;
                end
            end
            ADDR_IRQ_MASK: readdata[1:0] = irq_mask_q;
            ADDR_STATUS: begin
                readdata[4:0]            = 5'(fifo_count);
                readdata[STATUS_OVF_BIT]   = overflow_q;
                readdata[STATUS_EMPTY_BIT] = fifo_empty;
                readdata[STATUS_FULL_BIT]  = fifo_full;
            end
            ADDR_CONTROL:  readdata[CTRL_ENABLE_BIT] = enable_q;
            default:       readdata = '0;
        endcase
    end

    assign irq = (irq_mask_q[0] & ~fifo_empty) | (irq_mask_q[1] & overflow_q);

endmodule

// File: tb/tb_soc_system_adc_pio.sv
// Bench for soc_system_adc_pio: directed register/strobe sequences, a
// queue-based model of the sample path, and a per-cycle output compare.
module tb_soc_system_adc_pio;

    localparam int DATA_W     = 20;
    localparam int FIFO_DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [2:0]        address;
    logic              chipselect;
    logic              read_n;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] in_port;
    logic              in_strobe;
    logic              irq;

    int n_tests = 0;
    int n_fail  = 0;

    soc_system_adc_pio #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .in_strobe  (in_strobe),
        .irq        (irq)
    );

    // Clock
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } pend_t;

    pend_t             pend_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic              m_ovf      = 1'b0;
    logic [1:0]        m_mask     = 2'b0;
    logic              m_en       = 1'b0;
    logic              m_prev_stb = 1'b1;
    logic [DATA_W-1:0] m_inp1     = '0;
    logic [DATA_W-1:0] m_inp2     = '0;
    int                cyc        = 0;

    // A strobe rise seen at edge N lands in the FIFO at edge N+2.
    always @(posedge clk or negedge reset_n) begin
        bit                rd, wr, pop, push, flush, ovf_set;
        logic [DATA_W-1:0] pdata;
        if (!reset_n) begin
            exp_q.delete();
            pend_q.delete();
            m_ovf      = 1'b0;
            m_mask     = 2'b0;
            m_en       = 1'b0;
            m_prev_stb = 1'b1;
            m_inp1     = '0;
            m_inp2     = '0;
            cyc        = 0;
        end else begin
            cyc++;
            rd      = chipselect && !read_n;
            wr      = chipselect && !write_n;
            pop     = rd && address == 3'd1 && exp_q.size() > 0;
            flush   = wr && address == 3'd4 && writedata[1];
            push    = 1'b0;
            ovf_set = 1'b0;
            pdata   = '0;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                push  = m_en;
                pdata = pend_q[0].data;
                void'(pend_q.pop_front());
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (push && exp_q.size() == FIFO_DEPTH && !pop) ovf_set = 1'b1;
                if (pop) void'(exp_q.pop_front());
                if (push && exp_q.size() < FIFO_DEPTH) exp_q.push_back(pdata);
            end
            if (wr && address == 3'd3 && writedata[8]) m_ovf = 1'b0;
            if (ovf_set) m_ovf = 1'b1;
            if (wr && address == 3'd2) m_mask = writedata[1:0];
            if (wr && address == 3'd4) m_en = writedata[0];
            m_inp2 = m_inp1;
            m_inp1 = in_port;
            if (in_strobe && !m_prev_stb) pend_q.push_back('{cyc + 2, in_port});
            m_prev_stb = in_strobe;
        end
    end

    function automatic logic [31:0] model_rd(input logic [2:0] a);
        logic [31:0] r;
        int          n;
        r = 32'h0;
        n = exp_q.size();
        case (a)
            3'd0: r = 32'(m_inp2);
            3'd1: if (n > 0) r = 32'h8000_0000 | 32'(exp_q[0]);
            3'd2: r = 32'(m_mask);
            3'd3: r = 32'(n) | (32'(m_ovf) << 8) | ((n == 0) ? 32'h200 : 32'h0)
                      | ((n == FIFO_DEPTH) ? 32'h400 : 32'h0);
            3'd4: r = 32'(m_en);
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic logic model_irq();
        return (m_mask[0] && exp_q.size() > 0) || (m_mask[1] && m_ovf);
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        @(negedge clk);
        d = readdata;
        @(posedge clk);
        #2;
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #2;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic strobe_sample(input logic [DATA_W-1:0] v);
        in_port   = v;
        in_strobe = 1'b1;
        tick();
        tick();
        in_strobe = 1'b0;
        tick();
        tick();
    endtask

    // Strobe rise timed so the sample lands on the edge that ends a FIFO read.
    task automatic push_with_read(input logic [DATA_W-1:0] v, output logic [31:0] d);
        in_port   = v;
        in_strobe = 1'b1;
        tick();
        tick();
        in_strobe = 1'b0;
        bus_read(3'd1, d);
        tick();
    endtask

    task automatic push_with_write(input logic [DATA_W-1:0] v, input logic [2:0] a,
                                   input logic [31:0] wd);
        in_port   = v;
        in_strobe = 1'b1;
        tick();
        tick();
        in_strobe = 1'b0;
        bus_write(a, wd);
        tick();
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] d;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        in_strobe  = 1'b0;

        // Per-cycle compare of irq and readdata against the model.
        fork
            forever begin
                @(negedge clk);
                check("cyc_irq", {31'b0, irq}, {31'b0, model_irq()});
                check("cyc_readdata", readdata, model_rd(address));
            end
        join_none

        repeat (3) tick();
        address = 3'd3;
        #1;
        check("reset_status", readdata, 32'h0000_0200);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        repeat (5) tick();

        // Single sample path and latency
        bus_write(3'd4, 32'h1);
        read_check("control_enable", 3'd4, 32'h1);
        in_port   = 20'h12345;
        in_strobe = 1'b1;
        tick();
        tick();
        in_strobe = 1'b0;
        address   = 3'd3;
        #1;
        check("latency_2nd_edge", readdata, 32'h0000_0200);
        tick();
        check("latency_3rd_edge", readdata, 32'h0000_0001);
        read_check("data_reg", 3'd0, 32'h0001_2345);
        read_check("fifo_first", 3'd1, 32'h8001_2345);
        read_check("status_after_pop", 3'd3, 32'h0000_0200);
        read_check("fifo_empty_read", 3'd1, 32'h0);
        read_check("status_empty_read", 3'd3, 32'h0000_0200);

        // Unused addresses and IRQ_MASK width
        bus_write(3'd5, 32'hFFFF_FFFF);
        read_check("addr5", 3'd5, 32'h0);
        read_check("addr6", 3'd6, 32'h0);
        read_check("addr7", 3'd7, 32'h0);
        bus_write(3'd2, 32'hFF);
        read_check("irq_mask_rw", 3'd2, 32'h3);
        bus_write(3'd2, 32'h0);

        // Overfill: nine samples, ninth dropped
        for (int i = 0; i < 9; i++) strobe_sample(DATA_W'(i));
        read_check("status_overflow_full", 3'd3, 32'h0000_0508);
        for (int i = 0; i < 8; i++) read_check("fifo_order", 3'd1, 32'h8000_0000 | 32'(i));
        read_check("fifo_ninth_read", 3'd1, 32'h0);
        read_check("status_empty_ovf", 3'd3, 32'h0000_0300);
        bus_write(3'd3, 32'h0000_0100);
        read_check("status_ovf_cleared", 3'd3, 32'h0000_0200);

        // Push and pop on the same edge while full
        for (int i = 0; i < 8; i++) strobe_sample(DATA_W'(32'h10 + i));
        read_check("status_full", 3'd3, 32'h0000_0408);
        push_with_read(20'h00099, d);
        check("full_pushpop_oldest", d, 32'h8000_0010);
        read_check("full_pushpop_status", 3'd3, 32'h0000_0408);
        for (int i = 1; i < 8; i++) read_check("drain", 3'd1, 32'h8000_0010 + 32'(i));
        read_check("drain_last_new", 3'd1, 32'h8000_0099);

        // Push and pop on the same edge while not full
        strobe_sample(20'hAAAAA);
        strobe_sample(20'h55555);
        push_with_read(20'h0F0F0, d);
        check("pushpop_not_full", d, 32'h800A_AAAA);
        read_check("pushpop_count", 3'd3, 32'h0000_0002);
        bus_write(3'd4, 32'h3);
        read_check("flush_idle", 3'd3, 32'h0000_0200);

        // Interrupt sources
        bus_write(3'd2, 32'h1);
        check("irq_mask1_empty", {31'b0, irq}, 32'h0);
        strobe_sample(20'h00123);
        check("irq_not_empty", {31'b0, irq}, 32'h1);
        read_check("irq_pop_data", 3'd1, 32'h8000_0123);
        check("irq_after_pop", {31'b0, irq}, 32'h0);
        for (int i = 0; i < 9; i++) strobe_sample(DATA_W'(32'h200 + i));
        bus_write(3'd2, 32'h2);
        check("irq_overflow", {31'b0, irq}, 32'h1);
        bus_write(3'd3, 32'h0000_0100);
        check("irq_ovf_cleared", {31'b0, irq}, 32'h0);
        bus_write(3'd4, 32'h3);
        bus_write(3'd2, 32'h0);

        // Flush coincident with a push
        for (int i = 0; i < 4; i++) strobe_sample(DATA_W'(32'h300 + i));
        read_check("four_queued", 3'd3, 32'h0000_0004);
        push_with_write(20'h00777, 3'd4, 32'h3);
        read_check("flush_with_push", 3'd3, 32'h0000_0200);
        read_check("control_after_flush", 3'd4, 32'h1);

        // Reset mid-operation with the strobe held high
        strobe_sample(20'h00400);
        strobe_sample(20'h00401);
        in_strobe = 1'b1;
        reset_n   = 1'b0;
        tick();
        address = 3'd3;
        #1;
        check("mid_reset_status", readdata, 32'h0000_0200);
        tick();
        reset_n = 1'b1;
        bus_write(3'd4, 32'h1);
        repeat (6) tick();
        read_check("no_push_at_release", 3'd3, 32'h0000_0200);
        in_strobe = 1'b0;
        repeat (3) tick();
        strobe_sample(20'h00042);
        read_check("push_after_release", 3'd1, 32'h8000_0042);

        // Disabled capture ignores strobes
        bus_write(3'd4, 32'h0);
        for (int i = 0; i < 3; i++) strobe_sample(DATA_W'(32'h500 + i));
        read_check("disabled_count", 3'd3, 32'h0000_0200);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
